// File: rtl/pixel_state_ctrl_if.sv
// Sensor-side and host-side signal bundle for the pixel sequencing controller.
// The controller owns the master modport; the sensor/host model owns the slave.
interface pixel_state_ctrl_if #(
    parameter int DW = 8
);
    // host control
    logic          start;
    logic          abort;
    logic [15:0]   expose_len;
    logic          busy;
    logic [DW-1:0] pixel_value;
    logic          valid;

    // sensor strobes and shared data bus
    logic          erase;
    logic          expose;
    logic          ramp;
    logic          read;
    logic [DW-1:0] data_out;
    logic          data_oe;
    logic [DW-1:0] data_in;

    modport master (
        input  start, abort, expose_len, data_in,
        output erase, expose, ramp, read, data_out, data_oe,
               busy, pixel_value, valid
    );

    modport slave (
        output start, abort, expose_len, data_in,
        input  erase, expose, ramp, read, data_out, data_oe,
               busy, pixel_value, valid
    );
endinterface

// File: rtl/pixel_state_ctrl.sv
// Frame sequencer for the pixel sensor: erase, expose, ramp conversion with a
// ramp-synchronous counter on the shared DATA bus, bus turnaround, readout.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  S_IDLE    | all strobes low, waiting for start
//  S_ERASE   | erase high for ERASE_CYCLES cycles
//  S_EXPOSE  | expose high for max(expose_len,1) cycles
//  S_CONVERT | controller drives DATA with the step count, ramp toggles
//  S_TURN    | one dead cycle so sensor and controller never fight on DATA
//  S_READ    | read high for READ_CYCLES cycles, capture DATA on the last one
module pixel_state_ctrl #(
    parameter int DW           = 8,
    parameter int ERASE_CYCLES = 5,
    parameter int READ_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    pixel_state_ctrl_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_TURN,
        S_READ
    } state_t;

    localparam logic [15:0]   ERASE_LOAD = 16'(ERASE_CYCLES - 1);
    localparam logic [15:0]   READ_LOAD  = 16'(READ_CYCLES - 1);
    localparam logic [15:0]   TIMER_ONE  = 16'd1;
    localparam logic [DW-1:0] CNT_ONE    = DW'(1);
    localparam logic [DW-1:0] CNT_MAX    = '1;

    state_t        state, next_state;
    logic [15:0]   timer, next_timer;
    logic [15:0]   e_len, next_e_len;
    logic          phase, next_phase;
    logic [DW-1:0] count, next_count;
    logic          erase_q, next_erase;
    logic          expose_q, next_expose;
    logic          read_q, next_read;
    logic          oe_q, next_oe;
    logic          busy_q, next_busy;
    logic [DW-1:0] pixel_q, next_pixel;
    logic          valid_q, next_valid;

    // Every output comes straight from a flop; ramp is the phase bit itself
    // and data_out is the step counter itself.
    assign bus.erase       = erase_q;
    assign bus.expose      = expose_q;
    assign bus.ramp        = phase;
    assign bus.read        = read_q;
    assign bus.data_out    = count;
    assign bus.data_oe     = oe_q;
    assign bus.busy        = busy_q;
    assign bus.pixel_value = pixel_q;
    assign bus.valid       = valid_q;

    // State and registered-output update; reset clears the captured code too.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            timer    <= '0;
            e_len    <= TIMER_ONE;
            phase    <= 1'b0;
            count    <= '0;
            erase_q  <= 1'b0;
            expose_q <= 1'b0;
            read_q   <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            pixel_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state    <= next_state;
            timer    <= next_timer;
            e_len    <= next_e_len;
            phase    <= next_phase;
            count    <= next_count;
            erase_q  <= next_erase;
            expose_q <= next_expose;
            read_q   <= next_read;
            oe_q     <= next_oe;
            busy_q   <= next_busy;
            pixel_q  <= next_pixel;
            valid_q  <= next_valid;
        end
    end

    // Next state plus the value each output takes in that next state.
    always_comb begin
        next_state  = state;
        next_timer  = timer;
        next_e_len  = e_len;
        next_phase  = 1'b0;
        next_count  = count;
        next_erase  = 1'b0;
        next_expose = 1'b0;
        next_read   = 1'b0;
        next_oe     = 1'b0;
        next_pixel  = pixel_q;
        next_valid  = 1'b0;

        case (state)
            S_IDLE: begin
                next_count = '0;
                if (bus.start && !bus.abort) begin
                    next_state = S_ERASE;
                    next_e_len = (bus.expose_len == 16'd0) ? TIMER_ONE : bus.expose_len;
                    next_timer = ERASE_LOAD;
                    next_erase = 1'b1;
                end
            end

            S_ERASE: begin
                if (timer == 16'd0) begin
                    next_state  = S_EXPOSE;
                    next_timer  = e_len - TIMER_ONE;
                    next_expose = 1'b1;
                end else begin
                    next_timer = timer - TIMER_ONE;
                    next_erase = 1'b1;
                end
            end

            S_EXPOSE: begin
                if (timer == 16'd0) begin
                    next_state = S_CONVERT;
                    next_count = '0;
                    next_oe    = 1'b1;
                end else begin
                    next_timer  = timer - TIMER_ONE;
                    next_expose = 1'b1;
                end
            end

            S_CONVERT: begin
                // Count advances only as ramp falls, so data_out is settled
                // well before each rising edge the sensor compares on.
                if (phase && (count == CNT_MAX)) begin
                    next_state = S_TURN;
                    next_count = '0;
                end else begin
                    next_oe    = 1'b1;
                    next_phase = ~phase;
                    next_count = phase ? (count + CNT_ONE) : count;
                end
            end

            S_TURN: begin
                next_state = S_READ;
                next_timer = READ_LOAD;
                next_read  = 1'b1;
            end

            S_READ: begin
                if (timer == 16'd0) begin
                    next_state = S_IDLE;
                    next_pixel = bus.data_in;
                    next_valid = 1'b1;
                end else begin
                    next_timer = timer - TIMER_ONE;
                    next_read  = 1'b1;
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase

        // Abort drops everything without touching the last captured code.
        if (bus.abort && (state != S_IDLE)) begin
            next_state  = S_IDLE;
            next_timer  = '0;
            next_phase  = 1'b0;
            next_count  = '0;
            next_erase  = 1'b0;
            next_expose = 1'b0;
            next_read   = 1'b0;
            next_oe     = 1'b0;
            next_pixel  = pixel_q;
            next_valid  = 1'b0;
        end
    end

    // busy is registered alongside the state it describes.
    always_comb begin
        next_busy = (next_state != S_IDLE);
    end

endmodule

// File: tb/tb_pixel_state_ctrl.sv
// Directed bench for pixel_state_ctrl: stimulus pushes the expected per-frame
// result into a scoreboard; a negedge monitor measures each frame and checks it
// when valid appears.
module tb_pixel_state_ctrl;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [DW-1:0] target = 8'h80;
    logic [DW-1:0] sensor_code = '0;

    pixel_state_ctrl_if #(.DW(DW)) bus ();

    pixel_state_ctrl #(.DW(DW), .ERASE_CYCLES(5), .READ_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Sensor model: comparator trips when the ramp step equals the target code,
    // then drives the latched code when the controller releases the bus.
    always @(posedge clk) begin
        if (reset || bus.erase)
            sensor_code <= '0;
        else if (bus.ramp && bus.data_oe && (bus.data_out == target))
            sensor_code <= bus.data_out;
    end
    assign bus.data_in = bus.data_oe ? bus.data_out : sensor_code;

    typedef struct {
        logic [DW-1:0] pixel;
        int busy_n;
        int erase_n;
        int expose_n;
        int ramp_n;
        int read_n;
        int turn_n;
    } exp_t;

    exp_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic push_frame(input int e, input logic [DW-1:0] px);
        exp_t x;
        int ee;
        ee = (e == 0) ? 1 : e;
        x.pixel    = px;
        x.busy_n   = 5 + ee + 512 + 1 + 4;
        x.erase_n  = 5;
        x.expose_n = ee;
        x.ramp_n   = 256;
        x.read_n   = 4;
        x.turn_n   = 1;
        sb_q.push_back(x);
    endtask

    // Monitor state
    bit in_frame = 0;
    int f_busy, f_erase, f_expose, f_ramp, f_read, f_turn, f_seq, f_excl;
    logic p_erase = 0, p_ramp = 0;
    logic [DW-1:0] p_dout = '0;

    always @(negedge clk) begin
        exp_t x;
        int strobes;
        if (reset) begin
            in_frame = 0;
        end else begin
            if (bus.erase && !p_erase) begin
                in_frame = 1;
                f_busy = 0; f_erase = 0; f_expose = 0; f_ramp = 0;
                f_read = 0; f_turn = 0; f_seq = 0; f_excl = 0;
            end
            if (in_frame) begin
                if (bus.busy)   f_busy++;
                if (bus.erase)  f_erase++;
                if (bus.expose) f_expose++;
                if (bus.read)   f_read++;
                if (bus.busy && !bus.erase && !bus.expose && !bus.ramp && !bus.read && !bus.data_oe)
                    f_turn++;
                if (bus.ramp && !p_ramp) begin
                    if ((bus.data_out !== f_ramp[DW-1:0]) || (bus.data_out !== p_dout) || !bus.data_oe)
                        f_seq++;
                    f_ramp++;
                end
                strobes = int'(bus.erase) + int'(bus.expose) + int'(bus.ramp) + int'(bus.read);
                if (strobes > 1 || (bus.data_oe && bus.read)) f_excl++;
            end
            if (bus.valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_valid: valid=1 with no frame expected, pixel=0x%0h", bus.pixel_value);
                end else begin
                    x = sb_q.pop_front();
                    check("pixel_value", bus.pixel_value, x.pixel);
                    check("busy_cycles", f_busy, x.busy_n);
                    check("erase_cycles", f_erase, x.erase_n);
                    check("expose_cycles", f_expose, x.expose_n);
                    check("ramp_rises", f_ramp, x.ramp_n);
                    check("read_cycles", f_read, x.read_n);
                    check("turn_cycles", f_turn, x.turn_n);
                    check("ramp_data_seq_err", f_seq, 0);
                    check("strobe_overlap", f_excl, 0);
                    check("busy_low_at_valid", bus.busy, 0);
                end
                in_frame = 0;
            end
        end
        p_erase = bus.erase;
        p_ramp  = bus.ramp;
        p_dout  = bus.data_out;
    end

    task automatic wait_valid(input string name);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) break;
        end
        if (bus.valid !== 1'b1) begin
            n_checks++;
            $display("FAIL %s: valid never seen within 1000 cycles, busy=%0b", name, bus.busy);
        end
    endtask

    task automatic pulse_start(input logic [15:0] len);
        @(negedge clk);
        bus.start = 1'b1;
        bus.expose_len = len;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        int bad;
        bit seen;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.expose_len = 16'd0;

        // reset then idle
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.erase || bus.expose || bus.ramp || bus.read || bus.data_oe ||
                bus.busy || bus.valid || (bus.data_out != 0) || (bus.pixel_value != 0))
                bad++;
        end
        check("idle_outputs_nonzero", bad, 0);

        // abort overrides start in IDLE
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1; bus.expose_len = 16'd10;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        check("idle_abort_busy", bus.busy, 0);
        check("idle_abort_erase", bus.erase, 0);

        // nominal frame, code 0x80
        target = 8'h80;
        push_frame(10, 8'h80);
        pulse_start(16'd10);
        check("busy_after_start", bus.busy, 1);
        wait_valid("nominal");

        // expose_len = 0 behaves as 1
        target = 8'h35;
        push_frame(0, 8'h35);
        pulse_start(16'd0);
        wait_valid("zero_expose");

        // abort during CONVERT at count 0x40
        target = 8'hAA;
        pulse_start(16'd2);
        seen = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (bus.data_oe && bus.data_out == 8'h40) begin seen = 1; break; end
        end
        check("reached_count_40", seen, 1);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort_data_oe", bus.data_oe, 0);
        check("abort_ramp", bus.ramp, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_valid", bus.valid, 0);
        check("abort_pixel_kept", bus.pixel_value, 8'h35);
        @(negedge clk);
        bus.abort = 1'b0;
        repeat (10) @(negedge clk);

        // reset during EXPOSE
        pulse_start(16'd50);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.expose) begin seen = 1; break; end
        end
        check("reached_expose", seen, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_pixel_cleared", bus.pixel_value, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_expose", bus.expose, 0);

        // full frame after reset, expose 3
        target = 8'hC3;
        push_frame(3, 8'hC3);
        pulse_start(16'd3);
        wait_valid("after_reset");

        // start held high: back-to-back frames, top code
        target = 8'hFF;
        for (int k = 0; k < 4; k++) push_frame(1, 8'hFF);
        @(negedge clk);
        bus.expose_len = 16'd1;
        bus.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid("back_to_back");
            if (k < 3) begin
                @(negedge clk);
                check("b2b_restart_erase", bus.erase, 1);
                if (k == 2) bus.start = 1'b0;
            end
        end

        repeat (10) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
